alut_mem_clr13: RTL and testbench



---
 rtl/alut_mem_clr13.sv | 109 ++++++++++
 tb/tb_alut_mem_clr13.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/alut_mem_clr13.sv
// alut_mem_clr13: dual-port ALUT RAM with handshakes, add-wins collision rule and a clear sweep engine.
// Define ALUT_MEM_PARITY_EN to store an even-parity bit per word and flag read-side mismatches.
module alut_mem_clr13 #(
  parameter int DW = 83,
  parameter int AW = 8,
  parameter bit CLR_ON_RST = 1'b1
) (
  input  logic          pclk13,
  input  logic          n_p_reset13,
  input  logic          mem_req_add13,
  input  logic          mem_write_add13,
  input  logic [AW-1:0] mem_addr_add13,
  input  logic [DW-1:0] mem_write_data_add13,
  output logic [DW-1:0] mem_read_data_add13,
  output logic          mem_rvalid_add13,
  input  logic          mem_req_age13,
  input  logic          mem_write_age13,
  input  logic [AW-1:0] mem_addr_age13,
  input  logic [DW-1:0] mem_write_data_age13,
  output logic [DW-1:0] mem_read_data_age13,
  output logic          mem_rvalid_age13,
  input  logic          flush_req13,
  output logic          mem_busy13,
  output logic          collision13,
  output logic          par_err_add13,
  output logic          par_err_age13
);
  localparam int DD = 1 << AW;
`ifdef ALUT_MEM_PARITY_EN
  localparam int MW = DW + 1;
`else
  localparam int MW = DW;
`endif
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;
  logic [0:0]    state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic [MW-1:0] mem [DD];
  logic [MW-1:0] word_add, word_age, wword_add, wword_age;
  logic [DW-1:0] rdata_add_q, rdata_add_d, rdata_age_q, rdata_age_d;
  logic          rvalid_add_q, rvalid_add_d, rvalid_age_q, rvalid_age_d;
  logic          collision_q, collision_d, par_err_add_q, par_err_add_d, par_err_age_q, par_err_age_d;
  logic          idle, clearing, same, we_add, we_age;
  always_comb begin
    idle = n_p_reset13 & (state_q == ST_IDLE);
    clearing = n_p_reset13 & (state_q == ST_CLEAR);
    same = mem_addr_add13 == mem_addr_age13;
    word_add = mem[mem_addr_add13];
    word_age = mem[mem_addr_age13];
    rvalid_add_d = idle & mem_req_add13 & ~mem_write_add13;
    rvalid_age_d = idle & mem_req_age13 & ~mem_write_age13;
    we_add = idle & mem_req_add13 & mem_write_add13;
    collision_d = we_add & mem_req_age13 & mem_write_age13 & same;
    we_age = idle & mem_req_age13 & mem_write_age13 & ~collision_d;
    state_d = (state_q == ST_CLEAR) ? ((&clr_cnt_q) ? ST_IDLE : ST_CLEAR)
                                    : (flush_req13 ? ST_CLEAR : ST_IDLE);
    clr_cnt_d = (state_q == ST_CLEAR) ? clr_cnt_q + 1'b1 : '0;
    rdata_add_d = rvalid_add_d ? word_add[DW-1:0] : rdata_add_q;
    rdata_age_d = rvalid_age_d ? word_age[DW-1:0] : rdata_age_q;
`ifdef ALUT_MEM_PARITY_EN
    wword_add = {^mem_write_data_add13, mem_write_data_add13};
    wword_age = {^mem_write_data_age13, mem_write_data_age13};
    par_err_add_d = rvalid_add_d & (^word_add);
    par_err_age_d = rvalid_age_d & (^word_age);
`else
    wword_add = mem_write_data_add13;
    wword_age = mem_write_data_age13;
    par_err_add_d = 1'b0;
    par_err_age_d = 1'b0;
`endif
  end
  always_ff @(posedge pclk13) begin
    if (!n_p_reset13) begin
      state_q <= CLR_ON_RST ? ST_CLEAR : ST_IDLE;
      clr_cnt_q <= '0;
      rdata_add_q <= '0;
      rdata_age_q <= '0;
      rvalid_add_q <= 1'b0;
      rvalid_age_q <= 1'b0;
      collision_q <= 1'b0;
      par_err_add_q <= 1'b0;
      par_err_age_q <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_cnt_q <= clr_cnt_d;
      rdata_add_q <= rdata_add_d;
      rdata_age_q <= rdata_age_d;
      rvalid_add_q <= rvalid_add_d;
      rvalid_age_q <= rvalid_age_d;
      collision_q <= collision_d;
      par_err_add_q <= par_err_add_d;
      par_err_age_q <= par_err_age_d;
    end
  end
  // The array itself is never reset; the clear sweep is what zeroes it.
  always_ff @(posedge pclk13) begin
    if (clearing) mem[clr_cnt_q] <= '0;
    if (we_add) mem[mem_addr_add13] <= wword_add;
    if (we_age) mem[mem_addr_age13] <= wword_age;
  end
  assign mem_busy13 = clearing;
  assign mem_read_data_add13 = rdata_add_q;
  assign mem_read_data_age13 = rdata_age_q;
  assign mem_rvalid_add13 = rvalid_add_q;
  assign mem_rvalid_age13 = rvalid_age_q;
  assign collision13 = collision_q;
  assign par_err_add13 = par_err_add_q;
  assign par_err_age13 = par_err_age_q;
endmodule

// File: tb/tb_alut_mem_clr13.sv
// tb_alut_mem_clr13: randomized and directed checks of alut_mem_clr13 against an array-level reference model.
module tb_alut_mem_clr13;
  logic        pclk13 = 1'b0;
  logic        n_p_reset13 = 1'b0;
  logic        mem_req_add13 = 1'b0, mem_write_add13 = 1'b0;
  logic [7:0]  mem_addr_add13 = '0;
  logic [82:0] mem_write_data_add13 = '0, mem_read_data_add13;
  logic        mem_rvalid_add13;
  logic        mem_req_age13 = 1'b0, mem_write_age13 = 1'b0;
  logic [7:0]  mem_addr_age13 = '0;
  logic [82:0] mem_write_data_age13 = '0, mem_read_data_age13;
  logic        mem_rvalid_age13;
  logic        flush_req13 = 1'b0;
  logic        mem_busy13, collision13, par_err_add13, par_err_age13;

  alut_mem_clr13 dut (
    .pclk13(pclk13), .n_p_reset13(n_p_reset13),
    .mem_req_add13(mem_req_add13), .mem_write_add13(mem_write_add13),
    .mem_addr_add13(mem_addr_add13), .mem_write_data_add13(mem_write_data_add13),
    .mem_read_data_add13(mem_read_data_add13), .mem_rvalid_add13(mem_rvalid_add13),
    .mem_req_age13(mem_req_age13), .mem_write_age13(mem_write_age13),
    .mem_addr_age13(mem_addr_age13), .mem_write_data_age13(mem_write_data_age13),
    .mem_read_data_age13(mem_read_data_age13), .mem_rvalid_age13(mem_rvalid_age13),
    .flush_req13(flush_req13), .mem_busy13(mem_busy13), .collision13(collision13),
    .par_err_add13(par_err_add13), .par_err_age13(par_err_age13)
  );

  always #5 pclk13 = ~pclk13;

  int total = 0, bad = 0;
  logic [82:0] mdl [256];
  bit          corrupt [256];
  int          busy_left = 0;
  logic [82:0] exp_rd_a = '0, exp_rd_g = '0;

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [82:0] rnd_dw();
    logic [95:0] t = {$urandom, $urandom, $urandom};
    return t[82:0];
  endfunction

  task automatic start_clear();
    busy_left = 256;
    for (int i = 0; i < 256; i++) begin
      mdl[i] = '0;
      corrupt[i] = 1'b0;
    end
  endtask

  task automatic cyc(input logic ra, input logic wa, input logic [7:0] aa, input logic [82:0] da,
                     input logic rg, input logic wg, input logic [7:0] ag, input logic [82:0] dg,
                     input logic fl);
    logic ev_a = 1'b0, ev_g = 1'b0, ecol = 1'b0, epa = 1'b0, epg = 1'b0;
    mem_req_add13 = ra; mem_write_add13 = wa; mem_addr_add13 = aa; mem_write_data_add13 = da;
    mem_req_age13 = rg; mem_write_age13 = wg; mem_addr_age13 = ag; mem_write_data_age13 = dg;
    flush_req13 = fl;
    if (busy_left > 0) busy_left--;
    else begin
      if (ra && !wa) begin ev_a = 1'b1; exp_rd_a = mdl[aa]; epa = corrupt[aa]; end
      if (rg && !wg) begin ev_g = 1'b1; exp_rd_g = mdl[ag]; epg = corrupt[ag]; end
      ecol = ra && wa && rg && wg && aa == ag;
      if (rg && wg) begin mdl[ag] = dg; corrupt[ag] = 1'b0; end
      if (ra && wa) begin mdl[aa] = da; corrupt[aa] = 1'b0; end
      if (fl) start_clear();
    end
    @(posedge pclk13); #1;
    chk("rvalid_add", 96'(mem_rvalid_add13), 96'(ev_a));
    chk("rvalid_age", 96'(mem_rvalid_age13), 96'(ev_g));
    chk("rdata_add", 96'(mem_read_data_add13), 96'(exp_rd_a));
    chk("rdata_age", 96'(mem_read_data_age13), 96'(exp_rd_g));
    chk("collision", 96'(collision13), 96'(ecol));
    chk("busy", 96'(mem_busy13), 96'(busy_left > 0));
    chk("par_add", 96'(par_err_add13), 96'(epa));
    chk("par_age", 96'(par_err_age13), 96'(epg));
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 8'h0, '0, 0, 0, 8'h0, '0, 0);
  endtask

  task automatic do_reset();
    n_p_reset13 = 1'b0;
    mem_req_add13 = 1'b0; mem_req_age13 = 1'b0; flush_req13 = 1'b0;
    repeat (3) @(posedge pclk13);
    #1;
    chk("rst_busy", 96'(mem_busy13), 96'd0);
    chk("rst_rv_add", 96'(mem_rvalid_add13), 96'd0);
    chk("rst_rv_age", 96'(mem_rvalid_age13), 96'd0);
    chk("rst_rd_add", 96'(mem_read_data_add13), 96'd0);
    chk("rst_rd_age", 96'(mem_read_data_age13), 96'd0);
    chk("rst_col", 96'(collision13), 96'd0);
    exp_rd_a = '0;
    exp_rd_g = '0;
    n_p_reset13 = 1'b1;
    start_clear();
    #1;
    chk("busy_on_release", 96'(mem_busy13), 96'd1);
  endtask

  initial begin
    int busy_cnt;
    logic [82:0] a_val, b_val;
    do_reset();
    busy_cnt = 0;
    while (busy_left > 0) begin
      idle_n(1);
      if (mem_busy13) busy_cnt++;
    end
    chk("sweep_len", 96'(busy_cnt + 1), 96'd256);
    cyc(1, 0, 8'h33, '0, 0, 0, 8'h0, '0, 0);
    chk("read_after_clear", 96'(mem_read_data_add13), 96'd0);
    cyc(1, 1, 8'h05, 83'h1234, 0, 0, 8'h0, '0, 0);
    cyc(0, 0, 8'h0, '0, 1, 0, 8'h05, '0, 0);
    chk("age_rd_1234", 96'(mem_read_data_age13), 96'h1234);
    a_val = rnd_dw();
    b_val = rnd_dw();
    cyc(1, 1, 8'h10, a_val, 1, 1, 8'h10, b_val, 0);
    chk("collision_pulse", 96'(collision13), 96'd1);
    cyc(1, 0, 8'h10, '0, 0, 0, 8'h0, '0, 0);
    chk("collision_no_repeat", 96'(collision13), 96'd0);
    chk("add_wins", 96'(mem_read_data_add13), 96'(a_val));
    cyc(0, 0, 8'h0, '0, 1, 1, 8'h20, 83'h11, 0);
    cyc(1, 0, 8'h20, '0, 1, 1, 8'h20, 83'hFF, 0);
    chk("read_old", 96'(mem_read_data_add13), 96'h11);
    cyc(1, 0, 8'h20, '0, 0, 0, 8'h0, '0, 0);
    chk("read_new", 96'(mem_read_data_add13), 96'hFF);
    cyc(1, 1, 8'h40, 83'h7, 1, 1, 8'h41, 83'h9, 0);
    cyc(1, 0, 8'h41, '0, 1, 0, 8'h40, '0, 0);
    chk("diff_addr_both", 96'({mem_read_data_add13[7:0], mem_read_data_age13[7:0]}), 96'h0907);
    for (int i = 0; i < 4; i++) cyc(1, 1, 8'(i), rnd_dw(), 0, 0, 8'h0, '0, 0);
    cyc(0, 0, 8'h0, '0, 0, 0, 8'h0, '0, 1);
    for (int i = 0; i < 20; i++) cyc(1, i[0], 8'(i % 4), rnd_dw(), 1, ~i[0], 8'(i % 4), rnd_dw(), 1);
    while (busy_left > 0) idle_n(1);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 8'(i), '0, 0, 0, 8'h0, '0, 0);
      chk("flushed_zero", 96'(mem_read_data_add13), 96'd0);
    end
    cyc(1, 1, 8'h02, 83'h5, 0, 0, 8'h0, '0, 1);
    idle_n(10);
    do_reset();
    while (busy_left > 0) idle_n(1);
`ifdef ALUT_MEM_PARITY_EN
    cyc(1, 1, 8'h07, 83'h3C, 1, 1, 8'h08, 83'h5A, 0);
    dut.mem[7][3] = ~dut.mem[7][3];
    mdl[7][3] = ~mdl[7][3];
    corrupt[7] = 1'b1;
    cyc(1, 0, 8'h07, '0, 1, 0, 8'h08, '0, 0);
    chk("par_err_flip", 96'({par_err_add13, mem_rvalid_add13}), 96'b11);
    chk("par_ok_clean", 96'({par_err_age13, mem_rvalid_age13}), 96'b01);
`endif
    for (int i = 0; i < 500; i++) begin
      cyc($urandom_range(0, 1), $urandom_range(0, 1), 8'($urandom_range(0, 15)), rnd_dw(),
          $urandom_range(0, 1), $urandom_range(0, 1), 8'($urandom_range(0, 15)), rnd_dw(),
          $urandom_range(0, 99) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
